// File: rtl/riscv_lsu.sv
// RV32 load/store unit: byte/half/word loads with extension, and sub-word stores done as
// read-modify-write against a word-wide data cache with one cycle of read latency.
module riscv_lsu #(
    parameter int unsigned CHECK_ALIGN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        misalign_err,
    output logic [31:0] cache_addr,
    output logic        cache_write_en,
    output logic [31:0] cache_wdata,
    input  logic [31:0] cache_rdata
);

    typedef enum logic [1:0] {StIdle, StRd, StRdWait, StWr} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        we_q, we_d;
    logic        uns_q, uns_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;

    logic        misaligned;
    logic        reject;
    logic [31:0] acc_addr;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;
    logic [31:0] merged;

    always_comb begin
        misaligned = (req_size == 2'b11) ||
                     (req_size == 2'b01 && req_addr[0]) ||
                     (req_size == 2'b10 && req_addr[1:0] != 2'b00);
        reject     = (CHECK_ALIGN != 0) && misaligned;
        acc_addr   = req_addr;
        // Without alignment checking the offset bits below the access size are dropped.
        if (CHECK_ALIGN == 0) begin
            case (req_size)
                2'b00:   acc_addr = req_addr;
                2'b01:   acc_addr[0] = 1'b0;
                default: acc_addr[1:0] = 2'b00;
            endcase
        end
    end

    always_comb begin
        byte_sel = cache_rdata[{addr_q[1:0], 3'b000} +: 8];
        half_sel = cache_rdata[{addr_q[1], 4'b0000} +: 16];
        case (size_q)
            2'b00:   load_data = uns_q ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            2'b01:   load_data = uns_q ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: load_data = cache_rdata;
        endcase

        merged = cache_rdata;
        case (size_q)
            2'b00:   merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: merged = wdata_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        we_d    = we_q;
        uns_d   = uns_q;
        wdata_d = wdata_q;
        err_d   = 1'b0;

        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    addr_d  = acc_addr;
                    size_d  = req_size;
                    we_d    = req_we;
                    uns_d   = req_unsigned;
                    wdata_d = req_wdata;
                    if (reject) begin
                        err_d = 1'b1;
                    end else if (req_we && req_size[1]) begin
                        state_d = StWr;
                    end else begin
                        state_d = StRd;
                    end
                end
            end
            StRd: state_d = StRdWait;
            StRdWait: begin
                if (we_q) begin
                    // Merged word reuses the store-data register for the write cycle.
                    wdata_d = merged;
                    state_d = StWr;
                end else begin
                    state_d = StIdle;
                end
            end
            StWr: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            addr_q  <= 32'b0;
            size_q  <= 2'b0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            wdata_q <= 32'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            we_q    <= we_d;
            uns_q   <= uns_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        req_ready      = (state_q == StIdle);
        resp_valid     = (state_q == StWr) || (state_q == StRdWait && !we_q);
        resp_rdata     = (state_q == StRdWait && !we_q) ? load_data : 32'b0;
        misalign_err   = err_q;
        cache_addr     = (state_q != StIdle) ? {addr_q[31:2], 2'b00} : 32'b0;
        cache_write_en = (state_q == StWr);
        cache_wdata    = (state_q == StWr) ? wdata_q : 32'b0;
    end

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu: vector table through a checked instance plus an
// unchecked-alignment instance, with hand sequences for back-to-back and reset cases.
module tb_riscv_lsu;

    typedef struct {
        string       name;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        int          lat;
        logic [31:0] exp_data;
        logic [31:0] exp_waddr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel_b;
    logic        preload;
    logic        req_valid, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;

    logic        a_req_ready, a_resp_valid, a_err, a_we;
    logic [31:0] a_rdata_o, a_caddr, a_cwdata;
    logic [31:0] a_crdata;
    logic        b_req_ready, b_resp_valid, b_err, b_we;
    logic [31:0] b_rdata_o, b_caddr, b_cwdata;
    logic [31:0] b_crdata;

    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];
    int          a_strobes = 0;
    int          n_cmp = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    riscv_lsu #(.CHECK_ALIGN(1)) u_a (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid & ~sel_b),
        .req_ready      (a_req_ready),
        .req_we         (req_we),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (a_resp_valid),
        .resp_rdata     (a_rdata_o),
        .misalign_err   (a_err),
        .cache_addr     (a_caddr),
        .cache_write_en (a_we),
        .cache_wdata    (a_cwdata),
        .cache_rdata    (a_crdata)
    );

    riscv_lsu #(.CHECK_ALIGN(0)) u_b (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid & sel_b),
        .req_ready      (b_req_ready),
        .req_we         (req_we),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (b_resp_valid),
        .resp_rdata     (b_rdata_o),
        .misalign_err   (b_err),
        .cache_addr     (b_caddr),
        .cache_write_en (b_we),
        .cache_wdata    (b_cwdata),
        .cache_rdata    (b_crdata)
    );

    // Cache models: one-cycle registered read, write on strobe.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) begin
                mem_a[i] <= 32'h0;
                mem_b[i] <= 32'h0;
            end
            mem_a[8'h40] <= 32'h8180_7F01;
            mem_a[8'h80] <= 32'h1122_3344;
            mem_b[8'h40] <= 32'h8180_7F01;
        end else begin
            if (a_we) mem_a[a_caddr[9:2]] <= a_cwdata;
            if (b_we) mem_b[b_caddr[9:2]] <= b_cwdata;
        end
        a_crdata <= mem_a[a_caddr[9:2]];
        b_crdata <= mem_b[b_caddr[9:2]];
        if (a_we) a_strobes <= a_strobes + 1;
    end

    wire        m_ready = sel_b ? b_req_ready  : a_req_ready;
    wire        m_valid = sel_b ? b_resp_valid : a_resp_valid;
    wire [31:0] m_rdata = sel_b ? b_rdata_o    : a_rdata_o;
    wire        m_err   = sel_b ? b_err        : a_err;
    wire        m_we    = sel_b ? b_we         : a_we;
    wire [31:0] m_caddr = sel_b ? b_caddr      : a_caddr;
    wire [31:0] m_wdata = sel_b ? b_cwdata     : a_cwdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic we, input logic [1:0] size,
                                input logic uns, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic err, input int lat,
                                input logic [31:0] exp_data, input logic [31:0] exp_waddr);
        vec_t v;
        v.name = name; v.we = we; v.size = size; v.uns = uns; v.addr = addr;
        v.wdata = wdata; v.err = err; v.lat = lat; v.exp_data = exp_data;
        v.exp_waddr = exp_waddr;
        return v;
    endfunction

    task automatic set_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata);
        req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    endtask

    // Entered at a negedge; leaves at a negedge with the DUT back in idle.
    task automatic run_vec(input vec_t v);
        logic        rdy;
        int          lat, strobes, errs, bad_idle;
        logic [31:0] rd, wd, wa;
        lat = 0; strobes = 0; errs = 0; bad_idle = 0; rd = 0; wd = 0; wa = 0;
        set_req(v.we, v.size, v.uns, v.addr, v.wdata);
        req_valid = 1'b1;
        rdy = m_ready;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (m_valid && lat == 0) begin
                lat = c;
                rd  = m_rdata;
            end
            if (!m_valid && m_rdata != 32'h0) bad_idle++;
            if (m_we) begin
                strobes++;
                wd = m_wdata;
                wa = m_caddr;
            end
            if (m_err) errs++;
        end
        chk({v.name, " ready"}, 32'(rdy), 32'd1);
        chk({v.name, " misalign"}, 32'(errs), v.err ? 32'd1 : 32'd0);
        chk({v.name, " resp latency"}, 32'(lat), 32'(v.lat));
        chk({v.name, " strobes"}, 32'(strobes), (v.we && !v.err) ? 32'd1 : 32'd0);
        if (!v.err && v.we) begin
            chk({v.name, " cache_wdata"}, wd, v.exp_data);
            chk({v.name, " cache_addr"}, wa, v.exp_waddr);
        end else if (!v.err) begin
            chk({v.name, " resp_rdata"}, rd, v.exp_data);
        end
        chk({v.name, " rdata idle zero"}, 32'(bad_idle), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, " req_ready"}, 32'(a_req_ready), 32'd1);
        chk({name, " resp_valid"}, 32'(a_resp_valid), 32'd0);
        chk({name, " misalign_err"}, 32'(a_err), 32'd0);
        chk({name, " cache_write_en"}, 32'(a_we), 32'd0);
        chk({name, " cache_addr"}, a_caddr, 32'd0);
        chk({name, " cache_wdata"}, a_cwdata, 32'd0);
        chk({name, " resp_rdata"}, a_rdata_o, 32'd0);
    endtask

    vec_t vecs[15];
    vec_t bvecs[3];

    initial begin
        int          s0, accepted, busy;
        logic        rdy;
        logic [31:0] st_addr [3];
        logic [31:0] st_data [3];
        logic [1:0]  st_size [3];

        vecs[0]  = mk("lb 101",   0, 2'b00, 0, 32'h101, 0, 0, 2, 32'h0000_007F, 0);
        vecs[1]  = mk("lb 103",   0, 2'b00, 0, 32'h103, 0, 0, 2, 32'hFFFF_FF81, 0);
        vecs[2]  = mk("lhu 102",  0, 2'b01, 1, 32'h102, 0, 0, 2, 32'h0000_8180, 0);
        vecs[3]  = mk("lh 102",   0, 2'b01, 0, 32'h102, 0, 0, 2, 32'hFFFF_8180, 0);
        vecs[4]  = mk("lw 100",   0, 2'b10, 0, 32'h100, 0, 0, 2, 32'h8180_7F01, 0);
        vecs[5]  = mk("lbu 103",  0, 2'b00, 1, 32'h103, 0, 0, 2, 32'h0000_0081, 0);
        vecs[6]  = mk("sb 202",   1, 2'b00, 0, 32'h202, 32'h0000_00AB, 0, 3, 32'h11AB_3344,
                      32'h200);
        vecs[7]  = mk("sh 200",   1, 2'b01, 0, 32'h200, 32'h1234_BEEF, 0, 3, 32'h11AB_BEEF,
                      32'h200);
        vecs[8]  = mk("sw 304",   1, 2'b10, 0, 32'h304, 32'hDEAD_BEEF, 0, 1, 32'hDEAD_BEEF,
                      32'h304);
        vecs[9]  = mk("lw 304",   0, 2'b10, 0, 32'h304, 0, 0, 2, 32'hDEAD_BEEF, 0);
        vecs[10] = mk("lw 102 misalign", 0, 2'b10, 0, 32'h102, 0, 1, 0, 0, 0);
        vecs[11] = mk("lh 101 misalign", 0, 2'b01, 0, 32'h101, 0, 1, 0, 0, 0);
        vecs[12] = mk("size11 misalign", 0, 2'b11, 0, 32'h100, 0, 1, 0, 0, 0);
        vecs[13] = mk("sb 203",   1, 2'b00, 0, 32'h203, 32'hFFFF_FF5A, 0, 3, 32'h5AAB_BEEF,
                      32'h200);
        vecs[14] = mk("lh 202",   0, 2'b01, 0, 32'h202, 0, 0, 2, 32'h0000_5AAB, 0);

        bvecs[0] = mk("noalign lw 102", 0, 2'b10, 0, 32'h102, 0, 0, 2, 32'h8180_7F01, 0);
        bvecs[1] = mk("noalign lh 103", 0, 2'b01, 0, 32'h103, 0, 0, 2, 32'hFFFF_8180, 0);
        bvecs[2] = mk("noalign sw 306", 1, 2'b10, 0, 32'h306, 32'h1234_5678, 0, 1,
                      32'h1234_5678, 32'h304);

        rst = 1'b0; sel_b = 1'b0; preload = 1'b1; req_valid = 1'b0;
        set_req(0, 2'b00, 0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        #1 preload = 1'b0;
        @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b1;

        // First vector is accepted on the first posedge after reset release.
        foreach (vecs[i]) run_vec(vecs[i]);

        // Three stores with req_valid held high throughout.
        st_addr[0] = 32'h200; st_data[0] = 32'h0000_0077;  st_size[0] = 2'b00;
        st_addr[1] = 32'h300; st_data[1] = 32'hCAFE_F00D;  st_size[1] = 2'b10;
        st_addr[2] = 32'h206; st_data[2] = 32'h0000_1357;  st_size[2] = 2'b01;
        s0 = a_strobes; accepted = 0; busy = 0;
        set_req(1, st_size[0], 0, st_addr[0], st_data[0]);
        req_valid = 1'b1;
        for (int c = 0; c < 40 && accepted < 3; c++) begin
            rdy = a_req_ready;
            if (!rdy) busy++;
            @(posedge clk);
            if (rdy) begin
                accepted++;
                #1;
                if (accepted < 3) set_req(1, st_size[accepted], 0, st_addr[accepted],
                                          st_data[accepted]);
                else req_valid = 1'b0;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("b2b accepted", 32'(accepted), 32'd3);
        chk("b2b busy cycles", 32'(busy), 32'd4);
        chk("b2b strobes", 32'(a_strobes - s0), 32'd3);
        chk("b2b word 200", mem_a[8'h80], 32'h5AAB_BE77);
        chk("b2b word 300", mem_a[8'hC0], 32'hCAFE_F00D);
        chk("b2b word 204", mem_a[8'h81], 32'h1357_0000);

        // Reset during RD_WAIT of a byte store.
        s0 = a_strobes;
        set_req(1, 2'b00, 0, 32'h208, 32'h0000_0099);
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rdwait cache_addr", a_caddr, 32'h208);
        #2 rst = 1'b0;
        #1 chk_reset_outputs("mid-op reset");
        @(negedge clk);
        @(negedge clk);
        chk("mid-op reset strobes", 32'(a_strobes - s0), 32'd0);
        chk("mid-op reset word 208", mem_a[8'h82], 32'h0);
        rst = 1'b1;
        run_vec(mk("sw 20C after reset", 1, 2'b10, 0, 32'h20C, 32'h0BAD_F00D, 0, 1,
                   32'h0BAD_F00D, 32'h20C));

        // Reset asserted while the write strobe is up.
        s0 = a_strobes;
        set_req(1, 2'b10, 0, 32'h210, 32'h1111_1111);
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("wr strobe before reset", 32'(a_we), 32'd1);
        #1 rst = 1'b0;
        #1 chk("wr strobe dropped", 32'(a_we), 32'd0);
        @(negedge clk);
        chk("wr reset strobes", 32'(a_strobes - s0), 32'd0);
        chk("wr reset word 210", mem_a[8'h84], 32'h0);
        rst = 1'b1;
        run_vec(vecs[9]);

        sel_b = 1'b1;
        foreach (bvecs[i]) run_vec(bvecs[i]);
        chk("noalign word 304", mem_b[8'hC1], 32'h1234_5678);
        sel_b = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
